// File: rtl/box_renderer_pkg.sv
// Shared types for box_renderer: default widths, the box descriptor and the
// single-slot hit test used by every comparator.
package box_renderer_pkg;

  localparam int BR_COORD_W = 10;
  localparam int BR_COLOR_W = 12;

  typedef struct packed {
    logic [BR_COORD_W-1:0] x;
    logic [BR_COORD_W-1:0] y;
    logic [BR_COORD_W-1:0] w;
    logic [BR_COORD_W-1:0] h;
    logic [BR_COLOR_W-1:0] color;
    logic                  enable;
  } box_desc_t;

  // Far edges are formed one bit wider so boxes running past the screen edge
  // never wrap back to column/row 0; w=0 or h=0 yields an empty range.
  function automatic logic box_hit_test(input box_desc_t d,
                                        input logic [BR_COORD_W-1:0] px,
                                        input logic [BR_COORD_W-1:0] py);
    logic [BR_COORD_W:0] x_end;
    logic [BR_COORD_W:0] y_end;
    x_end = {1'b0, d.x} + {1'b0, d.w};
    y_end = {1'b0, d.y} + {1'b0, d.h};
    return d.enable && (px >= d.x) && ({1'b0, px} < x_end) &&
           (py >= d.y) && ({1'b0, py} < y_end);
  endfunction

endpackage

// File: rtl/box_renderer_if.sv
// Descriptor configuration port of box_renderer; game logic is the master.
interface box_renderer_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12,
  parameter int IDX_W   = 3
);
  logic               cfg_wr_en;
  logic [IDX_W-1:0]   cfg_idx;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic [COORD_W-1:0] cfg_w;
  logic [COORD_W-1:0] cfg_h;
  logic [COLOR_W-1:0] cfg_color;
  logic               cfg_enable;

  modport master (output cfg_wr_en, cfg_idx, cfg_x, cfg_y, cfg_w, cfg_h,
                  cfg_color, cfg_enable);
  modport slave  (input  cfg_wr_en, cfg_idx, cfg_x, cfg_y, cfg_w, cfg_h,
                  cfg_color, cfg_enable);
endinterface

// File: rtl/box_renderer_box_hit.sv
// One slot's S1 stage: registered hit bit (gated by pix_valid) and the slot
// colour captured alongside it.
module box_hit
  import box_renderer_pkg::*;
(
  input  logic                  pixel_clk,
  input  logic                  reset_n,
  input  box_desc_t             i_desc,
  input  logic [BR_COORD_W-1:0] i_x,
  input  logic [BR_COORD_W-1:0] i_y,
  input  logic                  i_valid,
  output logic                  o_hit,
  output logic [BR_COLOR_W-1:0] o_color
);

  logic                  r_hit;
  logic [BR_COLOR_W-1:0] r_color;

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_hit   <= 1'b0;
      r_color <= '0;
    end else begin
      r_hit   <= i_valid && box_hit_test(i_desc, i_x, i_y);
      r_color <= i_desc.color;
    end
  end

  assign o_hit   = r_hit;
  assign o_color = r_color;

endmodule

// File: rtl/box_renderer.sv
// Multi-box renderer: shadow/active descriptor banks, NUM_BOXES S1 comparators
// and an S2 priority encoder. Optional overlap tracking: BOX_RENDERER_COLLISION_EN.
module box_renderer
  import box_renderer_pkg::*;
#(
  parameter int                  NUM_BOXES = 8,
  parameter int                  COORD_W   = BR_COORD_W,
  parameter int                  COLOR_W   = BR_COLOR_W,
  parameter int                  IDX_W     = 3,
  parameter logic [COLOR_W-1:0]  BG_COLOR  = 12'h000
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic [COORD_W-1:0]   X_pix,
  input  logic [COORD_W-1:0]   Y_pix,
  input  logic                 pix_valid,
  input  logic                 frame_start,
  box_renderer_if.slave        cfg,
  output logic [COLOR_W-1:0]   pixel_color,
  output logic                 pixel_valid_out,
  output logic                 hit_any,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [NUM_BOXES-1:0] collision_mask
);

  box_desc_t              r_shadow [NUM_BOXES];
  box_desc_t              r_active [NUM_BOXES];
  box_desc_t              w_cfg_desc;
  logic [NUM_BOXES-1:0]   w_hit;
  logic [COLOR_W-1:0]     w_color [NUM_BOXES];
  logic                   r_valid_s1;
  logic                   w_win_any;
  logic [IDX_W-1:0]       w_win_idx;
  logic [COLOR_W-1:0]     w_win_color;
  logic [COLOR_W-1:0]     r_pixel_color;
  logic                   r_pixel_valid;
  logic                   r_hit_any;
  logic [IDX_W-1:0]       r_hit_idx;

  assign w_cfg_desc = '{x: cfg.cfg_x, y: cfg.cfg_y, w: cfg.cfg_w, h: cfg.cfg_h,
                        color: cfg.cfg_color, enable: cfg.cfg_enable};

  // Promotion reads the pre-write shadow, so a write on the frame_start edge waits a frame.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        if (frame_start) r_active[i] <= r_shadow[i];
        if (cfg.cfg_wr_en && (cfg.cfg_idx == IDX_W'(i))) r_shadow[i] <= w_cfg_desc;
      end
    end
  end

  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_slot
    box_hit u_box_hit (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .i_desc    (r_active[g]),
      .i_x       (X_pix),
      .i_y       (Y_pix),
      .i_valid   (pix_valid),
      .o_hit     (w_hit[g]),
      .o_color   (w_color[g])
    );
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) r_valid_s1 <= 1'b0;
    else          r_valid_s1 <= pix_valid;
  end

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    w_win_any   = 1'b0;
    w_win_idx   = '0;
    w_win_color = BG_COLOR;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win_any   = 1'b1;
        w_win_idx   = IDX_W'(i);
        w_win_color = w_color[i];
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_pixel_color <= BG_COLOR;
      r_pixel_valid <= 1'b0;
      r_hit_any     <= 1'b0;
      r_hit_idx     <= '0;
    end else begin
      r_pixel_color <= r_valid_s1 ? w_win_color : BG_COLOR;
      r_pixel_valid <= r_valid_s1;
      r_hit_any     <= w_win_any;
      r_hit_idx     <= w_win_idx;
    end
  end

  assign pixel_color     = r_pixel_color;
  assign pixel_valid_out = r_pixel_valid;
  assign hit_any         = r_hit_any;
  assign hit_idx         = r_hit_idx;

`ifdef BOX_RENDERER_COLLISION_EN
  logic [NUM_BOXES-1:0] r_coll_acc;
  logic [NUM_BOXES-1:0] r_coll_mask;
  logic [NUM_BOXES-1:0] w_coll_new;

  // More than one bit set in the S1 hit vector means an overlap on this pixel.
  assign w_coll_new = ((w_hit & (w_hit - NUM_BOXES'(1))) != '0) ? w_hit : '0;

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_coll_acc  <= '0;
      r_coll_mask <= '0;
    end else if (frame_start) begin
      r_coll_mask <= r_coll_acc;
      r_coll_acc  <= w_coll_new;
    end else begin
      r_coll_acc  <= r_coll_acc | w_coll_new;
    end
  end

  assign collision_mask = r_coll_mask;
`else
  assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_box_renderer.sv
// Directed bench for box_renderer with hand-computed expected pixels.
module tb_box_renderer;

  localparam int NB = 8;
  localparam int IW = 4;

  logic          clk;
  logic          reset_n;
  logic [9:0]    X_pix;
  logic [9:0]    Y_pix;
  logic          pix_valid;
  logic          frame_start;
  logic [11:0]   pixel_color;
  logic          pixel_valid_out;
  logic          hit_any;
  logic [IW-1:0] hit_idx;
  logic [NB-1:0] collision_mask;

  int n_checks = 0;
  int n_errors = 0;

  box_renderer_if #(.COORD_W(10), .COLOR_W(12), .IDX_W(IW)) cfg_if ();

  box_renderer #(.NUM_BOXES(NB), .IDX_W(IW)) dut (
    .pixel_clk       (clk),
    .reset_n         (reset_n),
    .X_pix           (X_pix),
    .Y_pix           (Y_pix),
    .pix_valid       (pix_valid),
    .frame_start     (frame_start),
    .cfg             (cfg_if.slave),
    .pixel_color     (pixel_color),
    .pixel_valid_out (pixel_valid_out),
    .hit_any         (hit_any),
    .hit_idx         (hit_idx),
    .collision_mask  (collision_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int w, input int h,
                           input logic [11:0] color, input logic en, input logic with_fs);
    @(negedge clk);
    cfg_if.cfg_wr_en  = 1'b1;
    cfg_if.cfg_idx    = IW'(idx);
    cfg_if.cfg_x      = 10'(x);
    cfg_if.cfg_y      = 10'(y);
    cfg_if.cfg_w      = 10'(w);
    cfg_if.cfg_h      = 10'(h);
    cfg_if.cfg_color  = color;
    cfg_if.cfg_enable = en;
    frame_start       = with_fs;
    @(negedge clk);
    cfg_if.cfg_wr_en  = 1'b0;
    frame_start       = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Apply one pixel and compare the outputs two clock edges later.
  task automatic probe(input string tag, input int x, input int y,
                       input logic [11:0] exp_color, input logic exp_hit, input int exp_idx);
    @(negedge clk);
    X_pix     = 10'(x);
    Y_pix     = 10'(y);
    pix_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val({tag, ".color"}, 32'(pixel_color), 32'(exp_color));
    check_val({tag, ".hit"},   32'(hit_any),     32'(exp_hit));
    check_val({tag, ".idx"},   32'(hit_idx),     32'(exp_idx));
    check_val({tag, ".vld"},   32'(pixel_valid_out), 32'd1);
  endtask

  logic [NB-1:0] exp_coll;

  initial begin
`ifdef BOX_RENDERER_COLLISION_EN
    exp_coll = 8'b0000_1001;
`else
    exp_coll = 8'b0000_0000;
`endif
    reset_n = 1'b0; X_pix = 10'd0; Y_pix = 10'd0; pix_valid = 1'b0; frame_start = 1'b0;
    cfg_if.cfg_wr_en = 1'b0; cfg_if.cfg_idx = '0; cfg_if.cfg_x = 10'd0; cfg_if.cfg_y = 10'd0;
    cfg_if.cfg_w = 10'd0; cfg_if.cfg_h = 10'd0; cfg_if.cfg_color = 12'h000; cfg_if.cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst.color", 32'(pixel_color), 32'h000);
    check_val("rst.vld",   32'(pixel_valid_out), 32'd0);
    check_val("rst.hit",   32'(hit_any), 32'd0);
    check_val("rst.idx",   32'(hit_idx), 32'd0);
    check_val("rst.coll",  32'(collision_mask), 32'd0);
    reset_n = 1'b1;

    // Empty frame
    pulse_fs();
    probe("empty0", 0, 0, 12'h000, 1'b0, 0);
    probe("empty1", 25, 150, 12'h000, 1'b0, 0);
    probe("empty2", 1023, 479, 12'h000, 1'b0, 0);
    pulse_fs();
    check_val("empty.coll", 32'(collision_mask), 32'd0);

    // Slot 2 edges
    cfg_write(2, 20, 100, 10, 120, 12'hFFF, 1'b1, 1'b0);
    probe("s2.prepromote", 20, 100, 12'h000, 1'b0, 0);
    pulse_fs();
    probe("s2.corner", 20, 100, 12'hFFF, 1'b1, 2);
    probe("s2.x30",    30, 100, 12'h000, 1'b0, 0);
    probe("s2.x19",    19, 100, 12'h000, 1'b0, 0);
    probe("s2.y219",   25, 219, 12'hFFF, 1'b1, 2);
    probe("s2.y220",   25, 220, 12'h000, 1'b0, 0);

    // Priority and collision
    cfg_write(0, 50, 50, 20, 20, 12'hF00, 1'b1, 1'b0);
    cfg_write(3, 60, 60, 20, 20, 12'h00F, 1'b1, 1'b0);
    pulse_fs();
    probe("prio.overlap", 65, 65, 12'hF00, 1'b1, 0);
    probe("prio.slot3",   75, 75, 12'h00F, 1'b1, 3);
    pulse_fs();
    check_val("coll.mask", 32'(collision_mask), 32'(exp_coll));

    // Write coinciding with frame_start waits one more frame
    cfg_write(1, 200, 200, 10, 10, 12'h0F0, 1'b1, 1'b1);
    probe("late.old", 205, 205, 12'h000, 1'b0, 0);
    pulse_fs();
    probe("late.new", 205, 205, 12'h0F0, 1'b1, 1);

    // Right-edge no-wrap, zero width, out-of-range index
    cfg_write(4, 1020, 0, 10, 500, 12'hABC, 1'b1, 1'b0);
    cfg_write(5, 0, 0, 0, 100, 12'h123, 1'b1, 1'b0);
    cfg_write(9, 0, 0, 5, 5, 12'h456, 1'b1, 1'b0);
    pulse_fs();
    probe("edge.x1023", 1023, 10, 12'hABC, 1'b1, 4);
    probe("edge.x1020", 1020, 10, 12'hABC, 1'b1, 4);
    probe("wrap.x0",    0, 10, 12'h000, 1'b0, 0);
    probe("wrap.x5",    5, 10, 12'h000, 1'b0, 0);
    probe("w0.and.idx9", 2, 2, 12'h000, 1'b0, 0);

    // Blanking: hits inside a box are suppressed when pix_valid is low
    @(negedge clk);
    X_pix = 10'd25; Y_pix = 10'd150; pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("blank.color", 32'(pixel_color), 32'h000);
    check_val("blank.vld",   32'(pixel_valid_out), 32'd0);
    check_val("blank.hit",   32'(hit_any), 32'd0);

    // Mid-line reset
    probe("prerst", 25, 150, 12'hFFF, 1'b1, 2);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mrst.color", 32'(pixel_color), 32'h000);
    check_val("mrst.hit",   32'(hit_any), 32'd0);
    check_val("mrst.vld",   32'(pixel_valid_out), 32'd0);
    check_val("mrst.coll",  32'(collision_mask), 32'd0);
    reset_n = 1'b1;
    pulse_fs();
    probe("postrst.s2", 25, 150, 12'h000, 1'b0, 0);
    probe("postrst.s0", 55, 55, 12'h000, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
